episode_controller: RTL

Environment sequencer for the Q-learning agent on the 5x5 grid world. Accepts one move per step from the agent, computes the next state and reward on the grid, and presents them on the agent's `next_state`/`next_reward` inputs. Ends episodes on goal, pit or step limit, restarts from the start cell and counts episodes until the training budget is spent. Sits between the agent and the test/top level and replaces the hand-driven stimulus currently used to exercise the agent.

---
 rtl/qlearn_pkg.sv | 44 ++++
 rtl/grid_step.sv | 41 ++++
 rtl/episode_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/qlearn_pkg.sv
// Shared grid, reward and FSM definitions for the Q-learning environment.
// STEP_PENALTY_EN selects a -1.0 reward on every non-terminal step.
package qlearn_pkg;

  localparam int GRID_DIM   = 5;
  localparam int NUM_STATES = 25;
  localparam int GOAL_STATE = 25;

  // bit (s-1) set for pit cells 3,4,7,13,14,17,19,22
  localparam logic [24:0] PIT_MASK = 25'h025304C;

  localparam logic [15:0] REWARD_GOAL = 16'h6400;
  localparam logic [15:0] REWARD_PIT  = 16'h9C00;
`ifdef STEP_PENALTY_EN
  localparam logic [15:0] REWARD_STEP = 16'hFF00;
`else
  localparam logic [15:0] REWARD_STEP = 16'h0000;
`endif

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_RIGHT = 2'd1,
    ACT_DOWN  = 2'd2,
    ACT_LEFT  = 2'd3
  } action_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RESTART  = 3'd1,
    ST_WAIT_ACT = 3'd2,
    ST_STEP     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // 5*row + col + 1 by shift-add
  function automatic logic [5:0] cell_of(
    input logic [2:0] row,
    input logic [2:0] col
  );
    return {1'b0, row, 2'b00} + {3'b000, row}
         + {3'b000, col} + 6'd1;
  endfunction

endpackage

// File: rtl/grid_step.sv
// Combinational move on the 5x5 grid: row/col/action -> new row/col/cell.
// Ports: row, col, act in; new_row, new_col, new_cell, is_pit, is_goal out.
module grid_step
  import qlearn_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  action_t    act,
  output logic [2:0] new_row,
  output logic [2:0] new_col,
  output logic [5:0] new_cell,
  output logic       is_pit,
  output logic       is_goal
);

  localparam logic [2:0] LAST = 3'(GRID_DIM - 1);

  logic [4:0] idx;

  // a move off the grid leaves the cell unchanged
  always_comb begin
    new_row = row;
    new_col = col;
    unique case (1'b1)
      act == ACT_UP:
        if (row != 3'd0) new_row = row - 3'd1;
      act == ACT_RIGHT:
        if (col != LAST) new_col = col + 3'd1;
      act == ACT_DOWN:
        if (row != LAST) new_row = row + 3'd1;
      act == ACT_LEFT:
        if (col != 3'd0) new_col = col - 3'd1;
    endcase
  end

  assign new_cell = cell_of(new_row, new_col);
  assign idx      = 5'(new_cell - 6'd1);
  assign is_pit   = PIT_MASK[idx];
  assign is_goal  = new_cell == 6'(GOAL_STATE);

endmodule

// File: rtl/episode_controller.sv
// Grid-world episode sequencer: takes agent moves, returns state/reward.
// Ports: clk, rst, start, act_valid, action in; act_ready, en, next_state,
// next_reward, step_valid, restart, episode_end, timeout, episode_count,
// done out. Macro STEP_PENALTY_EN enables the -1.0 step reward.
module episode_controller
  import qlearn_pkg::*;
#(
  parameter int MAX_STEPS    = 64,
  parameter int NUM_EPISODES = 1000,
  parameter int START_STATE  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        act_valid,
  input  logic [1:0]  action,
  output logic        act_ready,
  output logic        en,
  output logic [5:0]  next_state,
  output logic [15:0] next_reward,
  output logic        step_valid,
  output logic        restart,
  output logic        episode_end,
  output logic        timeout,
  output logic [15:0] episode_count,
  output logic        done
);

  localparam logic [2:0] START_ROW =
    3'((START_STATE - 1) / GRID_DIM);
  localparam logic [2:0] START_COL =
    3'((START_STATE - 1) % GRID_DIM);

  state_t      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  logic [7:0]  step_q, step_d;
  logic [5:0]  ns_q, ns_d;
  logic [15:0] rw_q, rw_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sv_q, sv_d;
  logic        rs_q, rs_d;
  logic        ee_q, ee_d;
  logic        to_q, to_d;

  logic [2:0]  g_row, g_col;
  logic [5:0]  g_cell;
  logic        g_pit, g_goal;
  logic [7:0]  step_inc;
  logic        limit_hit;
  logic        load_start;
  logic [15:0] reward;

  grid_step u_grid (
    .row      (row_q),
    .col      (col_q),
    .act      (action_t'(action)),
    .new_row  (g_row),
    .new_col  (g_col),
    .new_cell (g_cell),
    .is_pit   (g_pit),
    .is_goal  (g_goal)
  );

  assign step_inc  = step_q + 8'd1;
  assign limit_hit = step_inc == 8'(MAX_STEPS);

  always_comb begin
    unique case (1'b1)
      g_goal:  reward = REWARD_GOAL;
      g_pit:   reward = REWARD_PIT;
      default: reward = REWARD_STEP;
    endcase
  end

  // step results are registered at the handshake edge so they are
  // visible during STEP, ahead of a possible restart on the next cycle
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    step_d     = step_q;
    ns_d       = ns_q;
    rw_d       = rw_q;
    cnt_d      = cnt_q;
    sv_d       = 1'b0;
    rs_d       = 1'b0;
    ee_d       = 1'b0;
    to_d       = 1'b0;
    load_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) load_start = 1'b1;
      end
      ST_RESTART: begin
        state_d = ST_WAIT_ACT;
      end
      ST_WAIT_ACT: begin
        if (act_valid) begin
          state_d = ST_STEP;
          row_d   = g_row;
          col_d   = g_col;
          step_d  = step_inc;
          ns_d    = g_cell;
          rw_d    = reward;
          sv_d    = 1'b1;
          ee_d    = g_pit | g_goal | limit_hit;
          to_d    = limit_hit & ~g_pit & ~g_goal;
          if (g_pit | g_goal | limit_hit)
            cnt_d = cnt_q + 16'd1;
        end
      end
      ST_STEP: begin
        if (!ee_q)
          state_d = ST_WAIT_ACT;
        else if (cnt_q == 16'(NUM_EPISODES))
          state_d = ST_DONE;
        else
          load_start = 1'b1;
      end
      ST_DONE: begin
        if (start) begin
          load_start = 1'b1;
          cnt_d      = 16'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_start) begin
      state_d = ST_RESTART;
      row_d   = START_ROW;
      col_d   = START_COL;
      step_d  = 8'd0;
      ns_d    = 6'(START_STATE);
      rw_d    = 16'd0;
      rs_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      step_q  <= 8'd0;
      ns_q    <= 6'd0;
      rw_q    <= 16'd0;
      cnt_q   <= 16'd0;
      sv_q    <= 1'b0;
      rs_q    <= 1'b0;
      ee_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      step_q  <= step_d;
      ns_q    <= ns_d;
      rw_q    <= rw_d;
      cnt_q   <= cnt_d;
      sv_q    <= sv_d;
      rs_q    <= rs_d;
      ee_q    <= ee_d;
      to_q    <= to_d;
    end
  end

  assign act_ready     = state_q == ST_WAIT_ACT;
  assign en            = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done          = state_q == ST_DONE;
  assign next_state    = ns_q;
  assign next_reward   = rw_q;
  assign step_valid    = sv_q;
  assign restart       = rs_q;
  assign episode_end   = ee_q;
  assign timeout       = to_q;
  assign episode_count = cnt_q;

endmodule
